// File: rtl/regfile_arbiter_pkg.sv
// rtl/regfile_arbiter_pkg.sv - shared widths and arbiter state type for the register file arbiter
package regfile_arb_pkg;

   localparam int REG_ADDR_W = 3;
   localparam int REG_DATA_W = 8;
   localparam int NUM_REGS   = 8;

   typedef enum logic {
      ARB    = 1'b0,
      LOCKED = 1'b1
   } arb_state_e;

endpackage

// File: rtl/regfile_arbiter_if.sv
// rtl/regfile_arbiter_if.sv - requester command/response bus plus register file port bundle
interface regfile_arbiter_if #(
   parameter int NUM_REQ = 4
);
   import regfile_arb_pkg::*;

   logic [NUM_REQ-1:0]            REQ_VALID_i;
   logic [NUM_REQ-1:0]            REQ_WE_i;
   logic [NUM_REQ-1:0]            REQ_LOCK_i;
   logic [REG_ADDR_W*NUM_REQ-1:0] REQ_ADDR_i;
   logic [REG_DATA_W*NUM_REQ-1:0] REQ_WDATA_i;
   logic [NUM_REQ-1:0]            REQ_READY_o;
   logic [NUM_REQ-1:0]            RSP_VALID_o;
   logic [REG_DATA_W-1:0]         RSP_DATA_o;
   logic                          WR_EN_o;
   logic [REG_ADDR_W-1:0]         WR_ADDR_o;
   logic [REG_DATA_W-1:0]         WR_DATA_o;
   logic [REG_ADDR_W-1:0]         RD_ADDR_o;
   logic [REG_DATA_W-1:0]         RD_DATA_i;
   logic                          LOCK_TIMEOUT_o;

   // master: clients plus register file core; slave: the arbiter
   modport master (
      output REQ_VALID_i, REQ_WE_i, REQ_LOCK_i, REQ_ADDR_i, REQ_WDATA_i, RD_DATA_i,
      input  REQ_READY_o, RSP_VALID_o, RSP_DATA_o, WR_EN_o, WR_ADDR_o, WR_DATA_o,
             RD_ADDR_o, LOCK_TIMEOUT_o
   );

   modport slave (
      input  REQ_VALID_i, REQ_WE_i, REQ_LOCK_i, REQ_ADDR_i, REQ_WDATA_i, RD_DATA_i,
      output REQ_READY_o, RSP_VALID_o, RSP_DATA_o, WR_EN_o, WR_ADDR_o, WR_DATA_o,
             RD_ADDR_o, LOCK_TIMEOUT_o
   );

endinterface

// File: rtl/regfile_arbiter_rr_pick.sv
// rtl/regfile_arbiter_rr_pick.sv - combinational round-robin first-one search starting at ptr_i
module rr_pick #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   output logic [N-1:0]  gnt_o,
   output logic [IW-1:0] idx_o,
   output logic          any_o
);

   int j;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      any_o = 1'b0;
      j     = 0;
      for (int k = 0; k < N; k++) begin
         j = (int'(ptr_i) + k) % N;
         if (!any_o && req_i[j]) begin
            any_o    = 1'b1;
            gnt_o[j] = 1'b1;
            idx_o    = IW'(j);
         end
      end
   end

endmodule

// File: rtl/regfile_arbiter.sv
// rtl/regfile_arbiter.sv - round-robin arbiter with bus lock and lock timeout for an 8x8 register file
module regfile_arbiter
   import regfile_arb_pkg::*;
#(
   parameter int NUM_REQ  = 4,
   parameter int LOCK_MAX = 16
) (
   input  logic             CLK_i,
   input  logic             RST_i,
   regfile_arbiter_if.slave bus
);

   localparam int IW = $clog2(NUM_REQ);
   localparam int CW = $clog2(LOCK_MAX + 1);

   arb_state_e            state_q, state_d;
   logic [IW-1:0]         rr_ptr_q, rr_ptr_d;
   logic [IW-1:0]         owner_q, owner_d;
   logic [CW-1:0]         idle_q, idle_d;
   logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
   logic [REG_DATA_W-1:0] rsp_data_q, rsp_data_d;
   logic                  timeout_q, timeout_d;

   logic [NUM_REQ-1:0]    pick_req;
   logic [NUM_REQ-1:0]    gnt;
   logic [IW-1:0]         gnt_idx;
   logic                  gnt_any;

   function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] i);
      return (i == IW'(NUM_REQ - 1)) ? '0 : i + IW'(1);
   endfunction

   // while locked only the owner's request is visible to the picker
   assign pick_req = (state_q == LOCKED) ? (bus.REQ_VALID_i & (NUM_REQ'(1) << owner_q))
                                         : bus.REQ_VALID_i;

   rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
      .req_i (pick_req),
      .ptr_i (rr_ptr_q),
      .gnt_o (gnt),
      .idx_o (gnt_idx),
      .any_o (gnt_any)
   );

   always_ff @(posedge CLK_i) begin
      if (RST_i) begin
         state_q     <= ARB;
         rr_ptr_q    <= '0;
         owner_q     <= '0;
         idle_q      <= '0;
         rsp_valid_q <= '0;
         rsp_data_q  <= '0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         owner_q     <= owner_d;
         idle_q      <= idle_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         timeout_q   <= timeout_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      owner_d     = owner_q;
      idle_d      = idle_q;
      timeout_d   = 1'b0;
      rsp_valid_d = '0;
      rsp_data_d  = rsp_data_q;

      if (gnt_any && !bus.REQ_WE_i[gnt_idx]) begin
         rsp_valid_d = gnt;
         rsp_data_d  = bus.RD_DATA_i;
      end

      unique case (state_q)
         ARB: begin
            if (gnt_any) begin
               if (bus.REQ_LOCK_i[gnt_idx]) begin
                  state_d = LOCKED;
                  owner_d = gnt_idx;
                  idle_d  = '0;
               end else begin
                  rr_ptr_d = wrap_inc(gnt_idx);
               end
            end
         end
         LOCKED: begin
            if (gnt_any) begin
               if (bus.REQ_LOCK_i[gnt_idx]) begin
                  idle_d = '0;
               end else begin
                  state_d  = ARB;
                  rr_ptr_d = wrap_inc(owner_q);
               end
            end else if (idle_q == CW'(LOCK_MAX - 1)) begin
               // owner went quiet too long: force release so others are not starved
               state_d   = ARB;
               rr_ptr_d  = wrap_inc(owner_q);
               timeout_d = 1'b1;
            end else begin
               idle_d = idle_q + CW'(1);
            end
         end
         default: state_d = ARB;
      endcase
   end

   always_comb begin
      bus.REQ_READY_o    = gnt;
      bus.WR_EN_o        = 1'b0;
      bus.WR_ADDR_o      = '0;
      bus.RD_ADDR_o      = '0;
      bus.WR_DATA_o      = '0;
      bus.RSP_VALID_o    = rsp_valid_q;
      bus.RSP_DATA_o     = rsp_data_q;
      bus.LOCK_TIMEOUT_o = timeout_q;
      if (gnt_any) begin
         bus.WR_EN_o   = bus.REQ_WE_i[gnt_idx];
         bus.WR_ADDR_o = bus.REQ_ADDR_i[int'(gnt_idx)*REG_ADDR_W +: REG_ADDR_W];
         bus.RD_ADDR_o = bus.REQ_ADDR_i[int'(gnt_idx)*REG_ADDR_W +: REG_ADDR_W];
         bus.WR_DATA_o = bus.REQ_WDATA_i[int'(gnt_idx)*REG_DATA_W +: REG_DATA_W];
      end
   end

endmodule

// File: tb/tb_regfile_arbiter.sv
// tb/tb_regfile_arbiter.sv - scoreboard bench for regfile_arbiter with a rule-level reference model
module tb_regfile_arbiter;

   localparam int NR = 4;
   localparam int LM = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rf_init = 1'b1;
   logic started = 1'b0;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   regfile_arbiter_if #(.NUM_REQ(NR)) bus ();

   regfile_arbiter #(.NUM_REQ(NR), .LOCK_MAX(LM)) dut (
      .CLK_i (clk),
      .RST_i (rst),
      .bus   (bus)
   );

   // register file core seen by the arbiter
   logic [7:0] rf [8];
   always @(posedge clk) begin
      if (rf_init) begin
         for (int i = 0; i < 8; i++) rf[i] <= 8'(i * 37 + 5);
      end else if (bus.WR_EN_o) begin
         rf[bus.WR_ADDR_o] <= bus.WR_DATA_o;
      end
   end
   assign bus.RD_DATA_i = rf[bus.RD_ADDR_o];

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   typedef struct {
      int         due;
      logic [3:0] vec;
      logic [7:0] data;
   } rsp_t;
   rsp_t sbq [$];

   // reference model: lock owner, rotating priority start, idle run length, memory contents
   logic [7:0] ref_mem [8];
   bit m_locked = 0;
   int m_owner = 0;
   int m_ptr = 0;
   int m_idle = 0;
   bit m_to = 0;

   always @(negedge clk) begin : model
      int g;
      logic [3:0] v;
      logic [2:0] ea;
      logic [7:0] ed;
      bit ewe;
      rsp_t e;
      v = bus.REQ_VALID_i;
      if (rf_init) for (int i = 0; i < 8; i++) ref_mem[i] = 8'(i * 37 + 5);
      g = -1;
      if (m_locked) begin
         if (v[m_owner]) g = m_owner;
      end else begin
         for (int k = 0; k < NR; k++)
            if (g < 0 && v[(m_ptr + k) % NR]) g = (m_ptr + k) % NR;
      end
      ea  = (g >= 0) ? bus.REQ_ADDR_i[3*g +: 3] : 3'd0;
      ed  = (g >= 0) ? bus.REQ_WDATA_i[8*g +: 8] : 8'd0;
      ewe = (g >= 0) ? bus.REQ_WE_i[g] : 1'b0;
      if (started) begin
         chk("ready", 32'(bus.REQ_READY_o), (g >= 0) ? (32'd1 << g) : 32'd0);
         chk("wr_en", 32'(bus.WR_EN_o), 32'(ewe));
         chk("wr_addr", 32'(bus.WR_ADDR_o), 32'(ea));
         chk("rd_addr", 32'(bus.RD_ADDR_o), 32'(ea));
         chk("wr_data", 32'(bus.WR_DATA_o), 32'(ed));
         chk("timeout", 32'(bus.LOCK_TIMEOUT_o), 32'(m_to));
      end
      if (g >= 0 && ewe) ref_mem[ea] = ed;
      if (rst) begin
         m_locked = 0; m_owner = 0; m_ptr = 0; m_idle = 0; m_to = 0;
      end else begin
         if (g >= 0 && !ewe) begin
            e.due = cyc + 1; e.vec = 4'(1 << g); e.data = ref_mem[ea];
            sbq.push_back(e);
         end
         m_to = 0;
         if (!m_locked) begin
            if (g >= 0) begin
               if (bus.REQ_LOCK_i[g]) begin
                  m_locked = 1; m_owner = g; m_idle = 0;
               end else begin
                  m_ptr = (g + 1) % NR;
               end
            end
         end else if (g >= 0) begin
            if (bus.REQ_LOCK_i[g]) m_idle = 0;
            else begin m_locked = 0; m_ptr = (m_owner + 1) % NR; end
         end else if (m_idle == LM - 1) begin
            m_locked = 0; m_ptr = (m_owner + 1) % NR; m_to = 1;
         end else begin
            m_idle++;
         end
      end
   end

   logic [7:0] hold = 8'd0;
   bit was_rst = 1;

   always @(negedge clk) begin : monitor
      rsp_t e;
      #1;
      if (started) begin
         if (was_rst) hold = 8'd0;
         if (bus.RSP_VALID_o != 0) begin
            if (sbq.size() == 0) begin
               chk("rsp_unexpected", 32'(bus.RSP_VALID_o), 32'd0);
            end else begin
               e = sbq.pop_front();
               chk("rsp_cycle", cyc, e.due);
               chk("rsp_valid", 32'(bus.RSP_VALID_o), 32'(e.vec));
               chk("rsp_data", 32'(bus.RSP_DATA_o), 32'(e.data));
               hold = e.data;
            end
         end else begin
            chk("rsp_hold", 32'(bus.RSP_DATA_o), 32'(hold));
            if (sbq.size() > 0 && sbq[0].due <= cyc) begin
               chk("rsp_missing", 32'(bus.RSP_VALID_o), 32'(sbq[0].vec));
               void'(sbq.pop_front());
            end
         end
      end
      was_rst = rst;
   end

   logic [3:0] obs_ready, obs_rspv;
   logic [7:0] obs_rspd;
   logic       obs_to;

   task automatic step(input logic [3:0] v, input logic [3:0] we, input logic [3:0] lk,
                       input logic [11:0] a, input logic [31:0] d, input logic r);
      bus.REQ_VALID_i = v;
      bus.REQ_WE_i    = we;
      bus.REQ_LOCK_i  = lk;
      bus.REQ_ADDR_i  = a;
      bus.REQ_WDATA_i = d;
      rst             = r;
      #3;
      obs_ready = bus.REQ_READY_o;
      obs_rspv  = bus.RSP_VALID_o;
      obs_rspd  = bus.RSP_DATA_o;
      obs_to    = bus.LOCK_TIMEOUT_o;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int pulses, pulse_k, first_g;
      bus.REQ_VALID_i = '0; bus.REQ_WE_i = '0; bus.REQ_LOCK_i = '0;
      bus.REQ_ADDR_i = '0; bus.REQ_WDATA_i = '0;
      @(posedge clk); #1;
      repeat (2) step(4'b0, 4'b0, 4'b0, 12'd0, 32'd0, 1'b1);
      rf_init = 1'b0;
      started = 1'b1;

      step(4'b0, 4'b0, 4'b0, 12'd0, 32'd0, 1'b0);
      chk("reset_ready", 32'(obs_ready), 32'd0);
      chk("reset_rsp_valid", 32'(obs_rspv), 32'd0);
      chk("reset_rsp_data", 32'(obs_rspd), 32'd0);
      chk("reset_timeout", 32'(obs_to), 32'd0);

      // write then read back through requester 0
      step(4'b0001, 4'b0001, 4'b0, 12'd3, 32'hA5, 1'b0);
      chk("t1_wr_grant", 32'(obs_ready), 32'h1);
      step(4'b0001, 4'b0000, 4'b0, 12'd3, 32'd0, 1'b0);
      step(4'b0, 4'b0, 4'b0, 12'd0, 32'd0, 1'b0);
      chk("t1_rsp_valid", 32'(obs_rspv), 32'h1);
      chk("t1_rsp_data", 32'(obs_rspd), 32'hA5);

      // round robin with all four requesters holding reads
      step(4'b0, 4'b0, 4'b0, 12'd0, 32'd0, 1'b1);
      for (int k = 0; k < 5; k++) begin
         step(4'b1111, 4'b0, 4'b0, {3'd3, 3'd2, 3'd1, 3'd0}, 32'd0, 1'b0);
         chk("t2_grant", 32'(obs_ready), 32'd1 << (k % 4));
      end

      // locked read-modify-write by requester 1 with competitors waiting
      step(4'b0111, 4'b0000, 4'b0010, {3'd0, 3'd2, 3'd5, 3'd0}, 32'd0, 1'b0);
      chk("t3_lock_grant", 32'(obs_ready), 32'h2);
      step(4'b0111, 4'b0010, 4'b0000, {3'd0, 3'd2, 3'd5, 3'd0}, 32'h0000_1100, 1'b0);
      chk("t3_owner_grant", 32'(obs_ready), 32'h2);
      step(4'b0101, 4'b0000, 4'b0000, {3'd0, 3'd2, 3'd5, 3'd0}, 32'd0, 1'b0);
      chk("t3_next_grant", 32'(obs_ready), 32'h4);
      chk("t3_rf5", 32'(rf[5]), 32'h11);

      // requester 2 locks then goes quiet; requester 0 must wait for the timeout
      step(4'b0100, 4'b0100, 4'b0100, {3'd0, 3'd6, 3'd0, 3'd0}, 32'h0077_0000, 1'b0);
      chk("t4_lock_grant", 32'(obs_ready), 32'h4);
      pulses = 0; pulse_k = -1; first_g = -1;
      for (int k = 0; k < 24; k++) begin
         step(4'b0001, 4'b0000, 4'b0000, 12'd1, 32'd0, 1'b0);
         if (obs_to) begin pulses++; if (pulse_k < 0) pulse_k = k; end
         if (obs_ready != 0 && first_g < 0) first_g = k;
      end
      chk("t4_pulse_count", pulses, 1);
      chk("t4_pulse_cycle", pulse_k, LM);
      chk("t4_idle_cycles", first_g, LM);

      // reset while locked, one cycle after a read grant
      step(4'b0010, 4'b0000, 4'b0010, {3'd0, 3'd0, 3'd2, 3'd0}, 32'd0, 1'b0);
      chk("t5_lock_grant", 32'(obs_ready), 32'h2);
      step(4'b0, 4'b0, 4'b0, 12'd0, 32'd0, 1'b1);
      chk("t5_rsp_in_rst", 32'(obs_rspv), 32'h2);
      step(4'b1000, 4'b0000, 4'b0000, {3'd4, 3'd0, 3'd0, 3'd0}, 32'd0, 1'b0);
      chk("t5_rsp_valid", 32'(obs_rspv), 32'd0);
      chk("t5_rsp_data", 32'(obs_rspd), 32'd0);
      chk("t5_grant", 32'(obs_ready), 32'h8);

      // quiet bus
      step(4'b0, 4'b0, 4'b0, 12'd0, 32'd0, 1'b0);
      for (int k = 0; k < 10; k++) begin
         step(4'b0, 4'b0, 4'b0, 12'hFFF, 32'hFFFF_FFFF, 1'b0);
         chk("t6_ready", 32'(obs_ready), 32'd0);
         chk("t6_rsp_valid", 32'(obs_rspv), 32'd0);
      end

      // randomized traffic with occasional locks, quiet stretches and resets
      for (int k = 0; k < 600; k++) begin
         logic [3:0] v;
         v = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom & $urandom & $urandom);
         if ((k / 40) % 3 == 2) v = v & 4'($urandom & $urandom);
         step(v, 4'($urandom), ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0,
              12'($urandom), $urandom, ($urandom_range(0, 149) == 0));
      end

      repeat (3) step(4'b0, 4'b0, 4'b0, 12'd0, 32'd0, 1'b0);
      chk("sb_drain", sbq.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
